// File: rtl/multi_clk_en_gen_if.sv
// Configuration port of the clock-enable generator: valid/ready request
// carrying channel, divisor and phase, plus a one-cycle reject pulse.
interface multi_clk_en_gen_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/multi_clk_en_gen.sv
// Multi-channel clock-enable generator off a single reference clock.
// Each channel divides refclk by a runtime-programmable divisor, emitting a
// one-cycle enable pulse and a square-wave marker. Reconfiguration is taken
// through a single pending slot and lands only at the target channel's
// terminal count, so no channel ever sees a truncated or stretched period.
module multi_clk_en_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                refclk,
  input  logic                rst,
  multi_clk_en_gen_if.slave   cfg,
  output logic [NUM_CH-1:0]   outclk_en,
  output logic [NUM_CH-1:0]   outclk_sq,
  output logic                locked
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LC_W = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [1:0] {ACQUIRE, LOCKED_S, PENDING} state_t;

  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] sq_q;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] apply_ch;

  logic             pend_q;
  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic [DIV_W-1:0] pend_phase_q;
  logic             cfg_err_q;

  logic handshake;
  logic req_ok;
  logic accept;
  logic reject;
  logic apply;

  state_t          state_q, state_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;

  // Number of high cycles of the square marker: ceil(div/2), computed one
  // bit wider so div = 2^DIV_W-1 does not wrap.
  function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] t;
    t = {1'b0, div} + {{DIV_W{1'b0}}, 1'b1};
    return t[DIV_W:1];
  endfunction

  // Terminal-count decode per channel, and where the pending update lands.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tc[i]       = (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      apply_ch[i] = pend_q && (pend_ch_q == CH_W'(i)) && tc[i];
    end
  end

  assign apply = |apply_ch;

  // Request validation; the port only listens while the pending slot is empty.
  always_comb begin
    handshake = cfg.cfg_valid && !pend_q;
    req_ok    = (32'(cfg.cfg_ch) < NUM_CH) &&
                (cfg.cfg_div != '0) &&
                (cfg.cfg_phase < cfg.cfg_div);
    accept    = handshake && req_ok;
    reject    = handshake && !req_ok;
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign outclk_en     = en_q;
  assign outclk_sq     = sq_q;

  // Channel counters with registered enable/square decodes; an apply swaps in
  // the new divisor and phase while the enable still fires for the old period.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_W'(DEFAULT_DIV);
      end
      en_q <= '0;
      sq_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i] <= tc[i];
        sq_q[i] <= (cnt_q[i] < half_up(div_q[i]));
        if (apply_ch[i]) begin
          cnt_q[i] <= pend_phase_q;
          div_q[i] <= pend_div_q;
        end else if (tc[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Pending-update slot and the reject pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= reject;
      if (accept) begin
        pend_q       <= 1'b1;
        pend_ch_q    <= cfg.cfg_ch;
        pend_div_q   <= cfg.cfg_div;
        pend_phase_q <= cfg.cfg_phase;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ACQUIRE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock FSM next state: any apply restarts acquisition from zero.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (apply) begin
      state_d    = ACQUIRE;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        ACQUIRE: begin
          if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) state_d = LOCKED_S;
          else lock_cnt_d = lock_cnt_q + LC_W'(1);
        end
        LOCKED_S: if (accept) state_d = PENDING;
        PENDING:  state_d = PENDING;
        default:  state_d = ACQUIRE;
      endcase
    end
  end

  // Lock FSM output: locked stays high through a pending reconfiguration.
  always_comb begin
    locked = (state_q != ACQUIRE);
  end
endmodule

// File: tb/tb_multi_clk_en_gen.sv
// Self-checking bench for multi_clk_en_gen: a cycle model predicts every
// output each cycle through a queue, plus targeted timing checks.
module tb_multi_clk_en_gen;
  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 5;
  localparam int LOCK_CYCLES = 8;

  logic              refclk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] outclk_en;
  logic [NUM_CH-1:0] outclk_sq;
  logic              locked;

  multi_clk_en_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

  multi_clk_en_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg(cfg_if),
    .outclk_en(outclk_en), .outclk_sq(outclk_sq), .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] sq;
    logic              lk;
    logic              err;
    logic              rdy;
  } exp_t;

  typedef struct {
    int ch;
    int dv;
    int ph;
    bit err;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state, written from the behavioural description.
  int          m_cnt [NUM_CH];
  int          m_div [NUM_CH];
  bit          m_pend;
  int          m_pch, m_pdiv, m_pph;
  int          m_st;   // 0 acquire, 1 locked, 2 pending
  int          m_lcnt;
  bit [NUM_CH-1:0] m_en, m_sq;
  bit          m_err, m_lk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc, rej, ap, t;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0;
        m_div[i] = DEFAULT_DIV;
      end
      m_pend = 0; m_st = 0; m_lcnt = 0;
      m_en = '0; m_sq = '0; m_err = 0; m_lk = 0;
    end else begin
      acc = 0; rej = 0;
      if (cfg_if.cfg_valid && !m_pend) begin
        if (int'(cfg_if.cfg_ch) >= NUM_CH || cfg_if.cfg_div == 0 ||
            cfg_if.cfg_phase >= cfg_if.cfg_div) rej = 1;
        else acc = 1;
      end
      ap = m_pend && (m_cnt[m_pch] == m_div[m_pch] - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        t = (m_cnt[i] == m_div[i] - 1);
        m_en[i] = t;
        m_sq[i] = (m_cnt[i] < (m_div[i] + 1) / 2);
        if (ap && i == m_pch) begin
          m_cnt[i] = m_pph;
          m_div[i] = m_pdiv;
        end else begin
          m_cnt[i] = t ? 0 : m_cnt[i] + 1;
        end
      end
      if (ap) begin
        m_st = 0; m_lcnt = 0;
      end else if (m_st == 0) begin
        if (m_lcnt == LOCK_CYCLES - 1) m_st = 1;
        else m_lcnt++;
      end else if (m_st == 1 && acc) begin
        m_st = 2;
      end
      if (ap) m_pend = 0;
      if (acc) begin
        m_pend = 1;
        m_pch  = int'(cfg_if.cfg_ch);
        m_pdiv = int'(cfg_if.cfg_div);
        m_pph  = int'(cfg_if.cfg_phase);
      end
      m_err = rej;
      m_lk  = (m_st != 0);
    end
    exp_q.push_back('{en: m_en, sq: m_sq, lk: m_lk, err: m_err, rdy: !m_pend});
  endtask

  // One clock: predict, clock the DUT, then compare the oldest prediction.
  task automatic tick();
    exp_t e;
    model_step();
    @(posedge refclk);
    #1;
    e = exp_q.pop_front();
    chk("sb_en", 32'(outclk_en), 32'(e.en));
    chk("sb_sq", 32'(outclk_sq), 32'(e.sq));
    chk("sb_locked", 32'(locked), 32'(e.lk));
    chk("sb_err", 32'(cfg_if.cfg_err), 32'(e.err));
    chk("sb_ready", 32'(cfg_if.cfg_ready), 32'(e.rdy));
  endtask

  task automatic drive(input int ch, input int dv, input int ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 16'(dv);
    cfg_if.cfg_phase = 16'(ph);
  endtask

  task automatic idle();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, 32'(outclk_en), 0);
    chk({tag, "_sq"}, 32'(outclk_sq), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(cfg_if.cfg_err), 0);
    chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 1);
  endtask

  initial begin
    vec_t vt[4];
    bit   sqpat[5];
    bit   found;
    int   n;

    vt[0] = '{ch: 3, dv: 4, ph: 0, err: 1'b1};
    vt[1] = '{ch: 0, dv: 0, ph: 0, err: 1'b1};
    vt[2] = '{ch: 1, dv: 4, ph: 4, err: 1'b1};
    vt[3] = '{ch: 2, dv: 3, ph: 7, err: 1'b1};
    sqpat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    idle();
    repeat (3) tick();
    chk_reset_vals("reset");

    // Reset release: first enable on edge 5, square 1,1,1,0,0, lock on edge 8.
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4)  chk("en_before_first", 32'(outclk_en), 0);
      if (k == 5)  chk("en_first", 32'(outclk_en), 32'h7);
      if (k == 10) chk("en_second", 32'(outclk_en), 32'h7);
      if (k <= 5)  chk("sq0_pattern", 32'(outclk_sq[0]), 32'(sqpat[k-1]));
      if (k == 7)  chk("locked_pre", 32'(locked), 0);
      if (k == 8)  chk("locked_rise", 32'(locked), 1);
    end

    // Invalid requests from the table: one-cycle err pulse, ready stays high.
    for (int v = 0; v < 4; v++) begin
      drive(vt[v].ch, vt[v].dv, vt[v].ph);
      tick();
      chk("tbl_err", 32'(cfg_if.cfg_err), 32'(vt[v].err));
      chk("tbl_ready", 32'(cfg_if.cfg_ready), 1);
      idle();
      tick();
      chk("tbl_err_clear", 32'(cfg_if.cfg_err), 0);
    end

    // ch1 -> div 4 phase 2, accepted mid-period.
    drive(1, 4, 2);
    tick();
    chk("ch1_ready_low", 32'(cfg_if.cfg_ready), 0);
    idle();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (outclk_en[1]) found = 1;
      else begin
        chk("ch1_ready_hold", 32'(cfg_if.cfg_ready), 0);
        chk("ch1_locked_hold", 32'(locked), 1);
      end
    end
    chk("ch1_apply_seen", 32'(found), 1);
    chk("ch1_ready_back", 32'(cfg_if.cfg_ready), 1);
    chk("ch1_locked_drop", 32'(locked), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("ch1_new_period", 32'(outclk_en[1]), 32'(k == 2 || k == 6 || k == 10));
      if (k == 7) chk("ch1_relock_pre", 32'(locked), 0);
      if (k == 8) chk("ch1_relock", 32'(locked), 1);
    end

    // ch0 -> div 1: enable and square constantly high after apply.
    drive(0, 1, 0);
    tick();
    idle();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (cfg_if.cfg_ready) found = 1;
    end
    chk("ch0_apply_seen", 32'(found), 1);
    repeat (5) begin
      tick();
      chk("ch0_div1_en", 32'(outclk_en[0]), 1);
      chk("ch0_div1_sq", 32'(outclk_sq[0]), 1);
    end

    // Acceptance coincident with ch2 terminal count waits a full period.
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (outclk_en[2]) found = 1;
    end
    chk("ch2_pulse_seen", 32'(found), 1);
    repeat (4) tick();
    drive(2, 3, 0);
    tick();
    chk("ch2_tc_at_accept", 32'(outclk_en[2]), 1);
    chk("ch2_ready_low", 32'(cfg_if.cfg_ready), 0);
    idle();
    n = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      n++;
      if (cfg_if.cfg_ready) found = 1;
    end
    chk("ch2_apply_delay", 32'(n), 5);
    repeat (2) tick();
    chk("ch2_new_gap", 32'(outclk_en[2]), 0);
    tick();
    chk("ch2_new_pulse", 32'(outclk_en[2]), 1);

    // Reset while a reconfiguration is pending.
    drive(1, 7, 0);
    tick();
    chk("rst_pend_ready_low", 32'(cfg_if.cfg_ready), 0);
    idle();
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_pend");
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) chk("post_rst_en_pre", 32'(outclk_en), 0);
      if (k == 5 || k == 10) chk("post_rst_en_div5", 32'(outclk_en), 32'h7);
    end
    chk("post_rst_ready", 32'(cfg_if.cfg_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
